mem_arb_ctrl: RTL and testbench

- Two-requester controller in front of the single-port data RAM (word-wide, 1-cycle registered read, full-word writes only).
- Arbitrates between requester 0 (pipeline MEM stage) and requester 1 (program loader / debug port).
- Sequences each accepted request onto the RAM.
- Turns sub-word stores into a two-cycle read-modify-write, because the RAM has no byte enables.

---
 rtl/mem_arb_if.sv | 32 +++
 rtl/mem_arb_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Requester-side bus of the data-RAM arbiter. Both requesters share one
// interface instance. The master modport is the requester view and the
// slave modport is the arbiter view.
interface mem_arb_if #(
  parameter int AW = 32
);
  logic          m0_req,    m1_req;
  logic          m0_we,     m1_we;
  logic [AW-1:0] m0_addr,   m1_addr;
  logic [31:0]   m0_wdata,  m1_wdata;
  logic [3:0]    m0_be,     m1_be;
  logic          m0_gnt,    m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic          m0_err,    m1_err;
  logic [31:0]   rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m0_gnt, m0_rvalid, m0_err,
    input  m1_gnt, m1_rvalid, m1_err,
    input  rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m0_gnt, m0_rvalid, m0_err,
    output m1_gnt, m1_rvalid, m1_err,
    output rdata
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Two-requester controller in front of a single-port, word-wide data RAM
// with 1-cycle registered reads and no byte enables. Sub-word stores become
// a read-modify-write. Grants are issued only in IDLE.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: requester 0 always wins
// simultaneous requests (no round-robin pointer). Default: round-robin.
module mem_arb_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arb_if.slave      bus,
  output logic          ram_wen,
  output logic          ram_ren,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR} state_t;

  localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(DEPTH_WORDS) << 2;

  state_t        state;
  logic          lat_owner;
  logic          lat_err;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic [31:0]   rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic          rr_ptr;
`endif

  logic          both_req;
  logic          win;
  logic          grant;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;
  logic          sel_oor;
  logic          sel_partial;
  logic [31:0]   rdata_now;
  logic [31:0]   merged;

  // Arbitration and selection of the winning request's fields.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    both_req = bus.m0_req & bus.m1_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = ~bus.m0_req;
`else
    win = both_req ? rr_ptr : bus.m1_req;
`endif
    // rst_n gating keeps gnt low while reset is held with requests pending.
    grant       = rst_n && (state == IDLE) && (bus.m0_req | bus.m1_req);
    sel_we      = win ? bus.m1_we    : bus.m0_we;
    sel_addr    = win ? bus.m1_addr  : bus.m0_addr;
    sel_addr    = {sel_addr[AW-1:2], 2'b00};
    sel_wdata   = win ? bus.m1_wdata : bus.m0_wdata;
    sel_be      = win ? bus.m1_be    : bus.m0_be;
    sel_oor     = {1'b0, sel_addr} >= ADDR_LIMIT;
    sel_partial = (sel_be != 4'h0) && (sel_be != 4'hF);
  end

  // Byte merge for the write half of a read-modify-write.
  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

  // Requester responses and RAM strobes, decoded from state and the grant.
  always_comb begin
    bus.m0_gnt    = grant & ~win;
    bus.m1_gnt    = grant &  win;
    bus.m0_rvalid = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m0_err    = 1'b0;
    bus.m1_err    = 1'b0;
    ram_wen       = 1'b0;
    ram_ren       = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    rdata_now     = lat_err ? 32'h0 : ram_rdata;
    bus.rdata     = rdata_q;
    case (state)
      IDLE: begin
        if (grant && sel_oor && sel_we) begin
          bus.m0_err = ~win;
          bus.m1_err =  win;
        end else if (grant && !sel_oor) begin
          if (!sel_we || sel_partial) begin
            ram_ren  = 1'b1;
            ram_addr = sel_addr;
          end else if (sel_be == 4'hF) begin
            ram_wen   = 1'b1;
            ram_addr  = sel_addr;
            ram_wdata = sel_wdata;
          end
        end
      end
      RD_WAIT: begin
        bus.m0_rvalid = ~lat_owner;
        bus.m1_rvalid =  lat_owner;
        bus.m0_err    = ~lat_owner & lat_err;
        bus.m1_err    =  lat_owner & lat_err;
        bus.rdata     = rdata_now;
      end
      RMW_WR: begin
        ram_wen   = 1'b1;
        ram_addr  = lat_addr;
        ram_wdata = merged;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Sequencer: latches the granted request and steps through read/RMW states.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      lat_owner <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rdata_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            lat_owner <= win;
            lat_err   <= sel_oor;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_be    <= sel_be;
`ifndef MEM_ARB_FIXED_PRIO_EN
            if (both_req) rr_ptr <= ~win;
`endif
            if (!sel_we)                    state <= RD_WAIT;
            else if (!sel_oor && sel_partial) state <= RMW_RD;
          end
        end
        RD_WAIT: begin
          rdata_q <= rdata_now;
          state   <= IDLE;
        end
        RMW_RD:  state <= RMW_WR;
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl. It drives the inputs on the falling edge
// and checks the outputs 1 ns later. A behavioural RAM with a 1-cycle
// registered read sits on the RAM port.
module tb_mem_arb_ctrl;
  localparam int AW = 32;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_wen, ram_ren, busy;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic [31:0]   mem [0:1023];
  int            wen_count = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            snap;
  logic          exp_w;

  mem_arb_if #(.AW(AW)) bus ();

  mem_arb_ctrl #(.DEPTH_WORDS(1024), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_wen   (ram_wen),
    .ram_ren   (ram_ren),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM model: write on the edge, registered read held until the next read.
  always @(posedge clk) begin
    if (ram_wen) begin
      mem[ram_addr[11:2]] <= ram_wdata;
      wen_count <= wen_count + 1;
    end
    if (ram_ren) ram_rdata <= mem[ram_addr[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    if (!m) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
      bus.m0_wdata = wdata; bus.m0_be = be;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
      bus.m1_wdata = wdata; bus.m1_be = be;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt0",  bus.m0_gnt, 0);
    check("rst_gnt1",  bus.m1_gnt, 0);
    check("rst_rv0",   bus.m0_rvalid, 0);
    check("rst_err0",  bus.m0_err, 0);
    check("rst_busy",  busy, 0);
    check("rst_wen",   ram_wen, 0);
    check("rst_ren",   ram_ren, 0);
    check("rst_addr",  ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_rdata", bus.rdata, 0);
    rst_n = 1'b1;

    // m0 full write then read-back
    @(negedge clk); drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); #1;
    check("fw_gnt0",  bus.m0_gnt, 1);
    check("fw_gnt1",  bus.m1_gnt, 0);
    check("fw_wen",   ram_wen, 1);
    check("fw_ren",   ram_ren, 0);
    check("fw_addr",  ram_addr, 32'h10);
    check("fw_wdata", ram_wdata, 32'hDEADBEEF);
    check("fw_busy",  busy, 0);
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0); #1;
    check("rd_gnt0", bus.m0_gnt, 1);
    check("rd_ren",  ram_ren, 1);
    check("rd_wen",  ram_wen, 0);
    check("rd_addr", ram_addr, 32'h10);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("rd_rv0",    bus.m0_rvalid, 1);
    check("rd_rv1",    bus.m1_rvalid, 0);
    check("rd_rdata",  bus.rdata, 32'hDEADBEEF);
    check("rd_err0",   bus.m0_err, 0);
    check("rd_busy",   busy, 1);
    check("rd_nognt",  bus.m0_gnt, 0);
    check("rd_wen2",   ram_wen, 0);
    @(negedge clk); #1;
    check("rd_rv_off", bus.m0_rvalid, 0);
    check("rd_hold",   bus.rdata, 32'hDEADBEEF);
    check("rd_idle",   busy, 0);

    // Partial write (read-modify-write) by m1
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF); #1;
    check("seed_gnt1", bus.m1_gnt, 1);
    check("seed_wen",  ram_wen, 1);
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h0000AA00, 4'b0010); #1;
    check("pw_gnt1", bus.m1_gnt, 1);
    check("pw_ren",  ram_ren, 1);
    check("pw_wen",  ram_wen, 0);
    snap = wen_count;
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("pw_rd_busy", busy, 1);
    check("pw_rd_wen",  ram_wen, 0);
    check("pw_rd_ren",  ram_ren, 0);
    @(negedge clk); #1;
    check("pw_wr_busy",  busy, 1);
    check("pw_wr_wen",   ram_wen, 1);
    check("pw_wr_addr",  ram_addr, 32'h20);
    check("pw_wr_wdata", ram_wdata, 32'h1122AA44);
    @(negedge clk); #1;
    check("pw_idle",    busy, 0);
    check("pw_one_wen", 32'(wen_count - snap), 1);
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0); #1;
    check("pw_rb_gnt1", bus.m1_gnt, 1);
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("pw_rb_rv1",   bus.m1_rvalid, 1);
    check("pw_rb_rdata", bus.rdata, 32'h1122AA44);

    // Both requesters hold reads: grant order
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      exp_w = FIXED ? 1'b0 : 1'(k % 2);
      #1;
      check("rr_gnt0", bus.m0_gnt, {31'b0, ~exp_w});
      check("rr_gnt1", bus.m1_gnt, {31'b0, exp_w});
      @(negedge clk); #1;
      check("rr_rv0",   bus.m0_rvalid, {31'b0, ~exp_w});
      check("rr_rv1",   bus.m1_rvalid, {31'b0, exp_w});
      check("rr_nogrt", bus.m0_gnt | bus.m1_gnt, 0);
      check("rr_rdata", bus.rdata, exp_w ? 32'h1122AA44 : 32'hDEADBEEF);
      if (k == 3) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      @(negedge clk);
    end

    // Out-of-range read and write
    drive(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0); #1;
    check("oor_rd_gnt0", bus.m0_gnt, 1);
    check("oor_rd_ren",  ram_ren, 0);
    check("oor_rd_err0", bus.m0_err, 0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("oor_rd_rv0",   bus.m0_rvalid, 1);
    check("oor_rd_err",   bus.m0_err, 1);
    check("oor_rd_rdata", bus.rdata, 0);
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF); #1;
    check("oor_wr_gnt1", bus.m1_gnt, 1);
    check("oor_wr_err1", bus.m1_err, 1);
    check("oor_wr_wen",  ram_wen, 0);
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("oor_wr_busy", busy, 0);
    check("oor_wr_err0", bus.m1_err, 0);

    // Reset during RMW_RD abandons the write and clears the pointer
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h00000055, 4'b0001);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    check("ra_gnt0", bus.m0_gnt, 1);
    check("ra_gnt1", bus.m1_gnt, 0);
    snap = wen_count;
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("ra_busy",   busy, 1);
    check("ra_block1", bus.m1_gnt, 0);
    rst_n = 1'b0; #1;
    check("ra_busy0", busy, 0);
    check("ra_gnt1z", bus.m1_gnt, 0);
    check("ra_wen0",  ram_wen, 0);
    check("ra_ren0",  ram_ren, 0);
    @(negedge clk); #1;
    check("ra_wen1", ram_wen, 0);
    check("ra_idle", busy, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0); #1;
    check("ra_post_gnt0", bus.m0_gnt, 1);
    check("ra_post_gnt1", bus.m1_gnt, 0);
    check("ra_no_write",  32'(wen_count - snap), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("ra_rv0",    bus.m0_rvalid, 1);
    check("ra_intact", bus.rdata, 32'hDEADBEEF);

    // Back-to-back full writes
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'(4 * k), 32'hA0A0A000 + 32'(k), 4'hF); #1;
      check("b2b_gnt0",  bus.m0_gnt, 1);
      check("b2b_busy",  busy, 0);
      check("b2b_wen",   ram_wen, 1);
      check("b2b_addr",  ram_addr, 32'(4 * k));
    end
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0); #1;
    check("b2b_rd_gnt0", bus.m0_gnt, 1);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("b2b_rv0",   bus.m0_rvalid, 1);
    check("b2b_rdata", bus.rdata, 32'hA0A0A002);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
